instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the single-issue MIPS pipeline; the producer side of the Fetch→ID interface. It holds the PC and issues word requests to instruction memory over a request/acknowledge handshake. It delivers each fetched instruction with its PC and PC+4 to ID. It obeys ID's branch/jump redirect (`Request_Alt_PC`/`Alt_PC`) and freeze (`WANT_FREEZE`) outputs, tolerating arbitrary memory latency.

## Interface
- `RESET_PC`, 32'h00400000, address of first fetch after reset
- `CLK`  in  1  clock; all state changes on rising edge
- `RESET`  in  1  asynchronous, active-high reset
- `Alt_PC_IN`  in  32  redirect target from ID
- `Request_Alt_PC_IN`  in  1  redirect strobe from ID; one-cycle pulse
- `Freeze_IN`  in  1  ID's WANT_FREEZE; hold outputs to ID
- `IMem_Req`  out  1  fetch request to instruction memory
- `IMem_Addr`  out  32  word address of the request
- `IMem_Ack`  in  1  memory completes the request this cycle; may be high in the same cycle `IMem_Req` first rises
- `IMem_Data`  in  32  instruction word; valid only with `IMem_Ack`
- `Instr1_OUT`  out  32  instruction to ID (0 = nop bubble)
- `Instr_PC_OUT`  out  32  PC of `Instr1_OUT`
- `Instr_PC_Plus4_OUT`  out  32  `Instr_PC_OUT`+4
- `Instr_Valid_OUT`  out  1  `Instr1_OUT` is a real fetched instruction

## Operation
- Registers:
  - `pc`: next address to request.
  - `fetch_addr`: address of the outstanding request.
  - `buf`: one-word hold buffer, with its PC.
  - State: REQ, FULL, SQUASH.
- `IMem_Req` = (state REQ or SQUASH) and !RESET. `IMem_Addr` = `fetch_addr`. Once `IMem_Req` is high, neither it nor `IMem_Addr` changes until the cycle `IMem_Ack` is seen.
- Redirect (`Request_Alt_PC_IN`=1) has priority over Freeze. Its effect: `pc` <= `Alt_PC_IN`. It squashes the word being fetched in that same cycle, or the word in `buf`. Delay-slot instructions were already delivered in the previous cycle and are not affected.
- REQ:
  - Ack & redirect: discard data; `fetch_addr` <= `Alt_PC_IN`; stay REQ.
  - !Ack & redirect: go SQUASH.
  - Ack & !Freeze: deliver the word. `Instr1_OUT`<=`IMem_Data`, `Instr_PC_OUT`<=`fetch_addr`, `Plus4`<=`fetch_addr`+4, `Valid`<=1. Then `fetch_addr`, `pc` <= `fetch_addr`+4.
  - Ack & Freeze: write the word and its PC into `buf`; advance `pc`; go FULL.
  - !Ack: stay REQ, request still held.
- FULL (`IMem_Req`=0):
  - Redirect: drop `buf`; `fetch_addr` <= `Alt_PC_IN`; go REQ.
  - !Freeze: deliver `buf` as above; `fetch_addr` <= `pc`; go REQ.
  - Freeze: stay FULL.
- SQUASH: the request to the old address stays outstanding.
  - Ack: discard data; `fetch_addr` <= `pc`; go REQ.
  - A further redirect only updates `pc`.
- Outputs to ID:
  - While Freeze_IN=1, all four outputs hold their value.
  - Otherwise, in any cycle without a delivery, a bubble is sent: `Instr1_OUT`<=0, `Valid`<=0, PC outputs unchanged.
- Arithmetic: PC+4 is 32-bit modulo, so 32'hFFFFFFFC+4 = 0. The low two address bits are never altered.

## Timing
- Reset (async, RESET=1):
  - State REQ; `pc`=`fetch_addr`=`RESET_PC`; `buf` empty.
  - `Instr1_OUT`, `Instr_PC_OUT`, `Instr_PC_Plus4_OUT` = 0; `Instr_Valid_OUT`=0; `IMem_Req`=0.
  - First request is driven in the first cycle after RESET falls.
- Latency: a word acked in cycle n appears on the outputs after edge n. With zero-wait memory, one instruction is delivered per cycle.
- A redirect seen in cycle n puts `Alt_PC_IN` on `IMem_Addr` in cycle n+1 if no request is outstanding. Otherwise it appears in the cycle after the stale Ack.
- Freeze never drops an outstanding request. The word acked during a freeze is delivered exactly once, on the edge after Freeze falls.
- Reset asserted mid-request: abandon all state immediately. Memory shares RESET, so no stale Ack follows.

## Test plan
- Zero-wait memory, reset released: `IMem_Addr` steps 0x00400000, 0x00400004, … every cycle. `Instr_PC_OUT` trails by one cycle; `Valid` stays 1 continuously.
- Ack every third cycle: `IMem_Addr` and `IMem_Req` are stable between Acks. Two bubbles (`Instr1_OUT`=0, `Valid`=0) appear between deliveries.
- Redirect with Ack in the same cycle, while fetching 0x00400018 with `Alt_PC_IN`=0x00400100: the 0x00400018 word is never delivered. The next `IMem_Addr` is 0x00400100 and one bubble is sent.
- Redirect during a 3-cycle-latency fetch: `IMem_Addr` stays at the old address until Ack and that data is discarded. The next request is 0x00400100, and the first delivered PC is 0x00400100.
- `Instr1_OUT`=0x0000000C held while Freeze is high for 4 cycles, with an Ack arriving in freeze cycle 1: outputs hold 0x0000000C. `IMem_Req`=0 from the next cycle. The buffered word is delivered on the first edge after Freeze falls, with no loss and no duplicate.
- RESET pulsed while in SQUASH: all outputs go to 0 asynchronously and `IMem_Req`=0. After release, the first address is 0x00400000.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
// The fetch stage is the master and drives the request and its address.
interface instr_fetch_if;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack;
    logic [31:0] IMem_Data;

    modport master (
        output IMem_Req,
        output IMem_Addr,
        input  IMem_Ack,
        input  IMem_Data
    );

    modport slave (
        input  IMem_Req,
        input  IMem_Addr,
        output IMem_Ack,
        output IMem_Data
    );
endinterface

// File: rtl/instr_fetch.sv
// MIPS instruction fetch stage: holds the PC, fetches words over a req/ack bus, and feeds ID.
// Supports redirect (squash), freeze with a one-word hold buffer, and arbitrary memory latency.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   Alt_PC_IN,
    input  logic          Request_Alt_PC_IN,
    input  logic          Freeze_IN,
    instr_fetch_if.master imem,
    output logic [31:0]   Instr1_OUT,
    output logic [31:0]   Instr_PC_OUT,
    output logic [31:0]   Instr_PC_Plus4_OUT,
    output logic          Instr_Valid_OUT
);

    typedef enum logic [1:0] {StReq, StFull, StSquash} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] instr_pc4_q, instr_pc4_d;
    logic        valid_q, valid_d;

    logic        deliver;
    logic [31:0] dlv_data;
    logic [31:0] dlv_pc;

    assign imem.IMem_Req  = ((state_q == StReq) || (state_q == StSquash)) && !RESET;
    assign imem.IMem_Addr = fetch_addr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        buf_data_d   = buf_data_q;
        buf_pc_d     = buf_pc_q;
        deliver      = 1'b0;
        dlv_data     = 32'h0;
        dlv_pc       = 32'h0;

        case (state_q)
            StReq: begin
                if (Request_Alt_PC_IN) begin
                    pc_d = Alt_PC_IN;
                    if (imem.IMem_Ack) begin
                        fetch_addr_d = Alt_PC_IN;
                    end else begin
                        state_d = StSquash;
                    end
                end else if (imem.IMem_Ack) begin
                    pc_d = fetch_addr_q + 32'd4;
                    if (!Freeze_IN) begin
                        deliver      = 1'b1;
                        dlv_data     = imem.IMem_Data;
                        dlv_pc       = fetch_addr_q;
                        fetch_addr_d = fetch_addr_q + 32'd4;
                    end else begin
                        buf_data_d = imem.IMem_Data;
                        buf_pc_d   = fetch_addr_q;
                        state_d    = StFull;
                    end
                end
            end
            StFull: begin
                if (Request_Alt_PC_IN) begin
                    pc_d         = Alt_PC_IN;
                    fetch_addr_d = Alt_PC_IN;
                    state_d      = StReq;
                end else if (!Freeze_IN) begin
                    deliver      = 1'b1;
                    dlv_data     = buf_data_q;
                    dlv_pc       = buf_pc_q;
                    fetch_addr_d = pc_q;
                    state_d      = StReq;
                end
            end
            StSquash: begin
                if (Request_Alt_PC_IN) begin
                    pc_d = Alt_PC_IN;
                end
                // Stale word retires; resume at the latest redirect target.
                if (imem.IMem_Ack) begin
                    fetch_addr_d = pc_d;
                    state_d      = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    always_comb begin
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        instr_pc4_d = instr_pc4_q;
        valid_d     = valid_q;
        if (deliver) begin
            instr_d     = dlv_data;
            instr_pc_d  = dlv_pc;
            instr_pc4_d = dlv_pc + 32'd4;
            valid_d     = 1'b1;
        end else if (!Freeze_IN) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            buf_data_q   <= 32'h0;
            buf_pc_q     <= 32'h0;
            instr_q      <= 32'h0;
            instr_pc_q   <= 32'h0;
            instr_pc4_q  <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            buf_data_q   <= buf_data_d;
            buf_pc_q     <= buf_pc_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            instr_pc4_q  <= instr_pc4_d;
            valid_q      <= valid_d;
        end
    end

    assign Instr1_OUT         = instr_q;
    assign Instr_PC_OUT       = instr_pc_q;
    assign Instr_PC_Plus4_OUT = instr_pc4_q;
    assign Instr_Valid_OUT    = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; the bench plays instruction memory and ID.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alt;
    logic        redir;
    logic        freeze;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        ivalid;
    int          checks = 0;
    int          errors = 0;

    instr_fetch_if imem_bus ();

    instr_fetch #(.RESET_PC(32'h0040_0000)) dut (
        .CLK               (clk),
        .RESET             (rst),
        .Alt_PC_IN         (alt),
        .Request_Alt_PC_IN (redir),
        .Freeze_IN         (freeze),
        .imem              (imem_bus),
        .Instr1_OUT        (instr),
        .Instr_PC_OUT      (ipc),
        .Instr_PC_Plus4_OUT(ipc4),
        .Instr_Valid_OUT   (ivalid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {16'h1234, a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input bit a, input logic [31:0] d);
        imem_bus.IMem_Ack  = a;
        imem_bus.IMem_Data = a ? d : 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
        checks++; if (ipc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", ipc); end
        checks++; if (ipc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want 0", ipc4); end
        checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ivalid); end
        checks++; if (imem_bus.IMem_Req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_bus.IMem_Req); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (imem_bus.IMem_Req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", imem_bus.IMem_Req); end
        checks++; if (imem_bus.IMem_Addr !== 32'h0040_0000) begin errors++; $display("FAIL first_addr got %h want 00400000", imem_bus.IMem_Addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp;
        for (int i = 0; i < 6; i++) begin
            exp = 32'h0040_0000 + 32'(4 * i);
            mem(1'b1, word_at(exp));
            checks++; if (imem_bus.IMem_Addr !== exp) begin errors++; $display("FAIL zw_addr[%0d] got %h want %h", i, imem_bus.IMem_Addr, exp); end
            tick();
            checks++; if (ivalid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d] got %b want 1", i, ivalid); end
            checks++; if (ipc !== exp) begin errors++; $display("FAIL zw_pc[%0d] got %h want %h", i, ipc, exp); end
            checks++; if (ipc4 !== exp + 32'd4) begin errors++; $display("FAIL zw_pc4[%0d] got %h want %h", i, ipc4, exp + 32'd4); end
            checks++; if (instr !== word_at(exp)) begin errors++; $display("FAIL zw_instr[%0d] got %h want %h", i, instr, word_at(exp)); end
        end
        mem(1'b0, 32'h0);
    endtask

    task automatic test_redirect_same_cycle();
        checks++; if (imem_bus.IMem_Addr !== 32'h0040_0018) begin errors++; $display("FAIL rs_pre_addr got %h want 00400018", imem_bus.IMem_Addr); end
        mem(1'b1, word_at(32'h0040_0018));
        redir = 1'b1;
        alt   = 32'h0040_0100;
        tick();
        redir = 1'b0;
        mem(1'b0, 32'h0);
        checks++; if (ivalid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL rs_bubble got %b/%h want 0/0", ivalid, instr); end
        checks++; if (ipc !== 32'h0040_0014) begin errors++; $display("FAIL rs_pc_hold got %h want 00400014", ipc); end
        checks++; if (imem_bus.IMem_Addr !== 32'h0040_0100) begin errors++; $display("FAIL rs_addr got %h want 00400100", imem_bus.IMem_Addr); end
        checks++; if (imem_bus.IMem_Req !== 1'b1) begin errors++; $display("FAIL rs_req got %b want 1", imem_bus.IMem_Req); end
    endtask

    task automatic test_slow_ack();
        logic [31:0] exp;
        for (int w = 0; w < 2; w++) begin
            exp = 32'h0040_0100 + 32'(4 * w);
            for (int c = 0; c < 2; c++) begin
                checks++; if (imem_bus.IMem_Req !== 1'b1 || imem_bus.IMem_Addr !== exp) begin errors++; $display("FAIL sa_hold[%0d.%0d] got %b/%h want 1/%h", w, c, imem_bus.IMem_Req, imem_bus.IMem_Addr, exp); end
                tick();
                checks++; if (ivalid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL sa_bubble[%0d.%0d] got %b/%h want 0/0", w, c, ivalid, instr); end
            end
            mem(1'b1, word_at(exp));
            checks++; if (imem_bus.IMem_Addr !== exp) begin errors++; $display("FAIL sa_addr[%0d] got %h want %h", w, imem_bus.IMem_Addr, exp); end
            tick();
            mem(1'b0, 32'h0);
            checks++; if (ivalid !== 1'b1 || ipc !== exp || instr !== word_at(exp)) begin errors++; $display("FAIL sa_deliver[%0d] got %b/%h/%h want 1/%h/%h", w, ivalid, ipc, instr, exp, word_at(exp)); end
        end
    endtask

    task automatic test_redirect_latency();
        redir = 1'b1;
        alt   = 32'h0040_0100;
        mem(1'b0, 32'h0);
        tick();
        redir = 1'b0;
        checks++; if (imem_bus.IMem_Req !== 1'b1 || imem_bus.IMem_Addr !== 32'h0040_0108) begin errors++; $display("FAIL rl_hold1 got %b/%h want 1/00400108", imem_bus.IMem_Req, imem_bus.IMem_Addr); end
        tick();
        checks++; if (imem_bus.IMem_Addr !== 32'h0040_0108) begin errors++; $display("FAIL rl_hold2 got %h want 00400108", imem_bus.IMem_Addr); end
        mem(1'b1, word_at(32'h0040_0108));
        tick();
        mem(1'b0, 32'h0);
        checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL rl_discard got %b want 0", ivalid); end
        checks++; if (imem_bus.IMem_Addr !== 32'h0040_0100) begin errors++; $display("FAIL rl_new_addr got %h want 00400100", imem_bus.IMem_Addr); end
        mem(1'b1, word_at(32'h0040_0100));
        tick();
        mem(1'b0, 32'h0);
        checks++; if (ivalid !== 1'b1 || ipc !== 32'h0040_0100) begin errors++; $display("FAIL rl_first got %b/%h want 1/00400100", ivalid, ipc); end
    endtask

    task automatic test_freeze();
        mem(1'b1, 32'h0000_000C);
        tick();
        mem(1'b0, 32'h0);
        checks++; if (instr !== 32'h0000_000C || ipc !== 32'h0040_0104) begin errors++; $display("FAIL fz_setup got %h/%h want 0000000c/00400104", instr, ipc); end
        freeze = 1'b1;
        mem(1'b1, 32'h2222_2222);
        tick();
        mem(1'b0, 32'h0);
        checks++; if (instr !== 32'h0000_000C || ivalid !== 1'b1 || ipc !== 32'h0040_0104 || ipc4 !== 32'h0040_0108) begin errors++; $display("FAIL fz_hold1 got %h/%b/%h/%h want 0000000c/1/00400104/00400108", instr, ivalid, ipc, ipc4); end
        checks++; if (imem_bus.IMem_Req !== 1'b0) begin errors++; $display("FAIL fz_req1 got %b want 0", imem_bus.IMem_Req); end
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++; if (instr !== 32'h0000_000C || ivalid !== 1'b1 || imem_bus.IMem_Req !== 1'b0) begin errors++; $display("FAIL fz_hold%0d got %h/%b/%b want 0000000c/1/0", k, instr, ivalid, imem_bus.IMem_Req); end
        end
        freeze = 1'b0;
        tick();
        checks++; if (instr !== 32'h2222_2222 || ipc !== 32'h0040_0108 || ivalid !== 1'b1) begin errors++; $display("FAIL fz_release got %h/%h/%b want 22222222/00400108/1", instr, ipc, ivalid); end
        checks++; if (imem_bus.IMem_Req !== 1'b1 || imem_bus.IMem_Addr !== 32'h0040_010C) begin errors++; $display("FAIL fz_next_req got %b/%h want 1/0040010c", imem_bus.IMem_Req, imem_bus.IMem_Addr); end
        tick();
        checks++; if (ivalid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL fz_no_dup got %b/%h want 0/0", ivalid, instr); end
    endtask

    task automatic test_wrap();
        freeze = 1'b1;
        mem(1'b1, 32'h3333_3333);
        tick();
        mem(1'b0, 32'h0);
        checks++; if (imem_bus.IMem_Req !== 1'b0) begin errors++; $display("FAIL wr_full_req got %b want 0", imem_bus.IMem_Req); end
        redir = 1'b1;
        alt   = 32'hFFFF_FFFC;
        tick();
        redir  = 1'b0;
        freeze = 1'b0;
        checks++; if (imem_bus.IMem_Req !== 1'b1 || imem_bus.IMem_Addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_redir_addr got %b/%h want 1/fffffffc", imem_bus.IMem_Req, imem_bus.IMem_Addr); end
        mem(1'b1, 32'h4444_4444);
        tick();
        mem(1'b0, 32'h0);
        checks++; if (instr !== 32'h4444_4444 || ipc !== 32'hFFFF_FFFC || ipc4 !== 32'h0) begin errors++; $display("FAIL wr_deliver got %h/%h/%h want 44444444/fffffffc/00000000", instr, ipc, ipc4); end
        checks++; if (imem_bus.IMem_Addr !== 32'h0) begin errors++; $display("FAIL wr_next_addr got %h want 0", imem_bus.IMem_Addr); end
    endtask

    task automatic test_reset_in_squash();
        redir = 1'b1;
        alt   = 32'h0040_0100;
        mem(1'b0, 32'h0);
        tick();
        redir = 1'b0;
        checks++; if (imem_bus.IMem_Req !== 1'b1 || imem_bus.IMem_Addr !== 32'h0) begin errors++; $display("FAIL rq_squash got %b/%h want 1/0", imem_bus.IMem_Req, imem_bus.IMem_Addr); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (instr !== 32'h0 || ipc !== 32'h0 || ipc4 !== 32'h0 || ivalid !== 1'b0) begin errors++; $display("FAIL rq_outputs got %h/%h/%h/%b want 0/0/0/0", instr, ipc, ipc4, ivalid); end
        checks++; if (imem_bus.IMem_Req !== 1'b0) begin errors++; $display("FAIL rq_req got %b want 0", imem_bus.IMem_Req); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (imem_bus.IMem_Req !== 1'b1 || imem_bus.IMem_Addr !== 32'h0040_0000) begin errors++; $display("FAIL rq_restart got %b/%h want 1/00400000", imem_bus.IMem_Req, imem_bus.IMem_Addr); end
        mem(1'b1, word_at(32'h0040_0000));
        tick();
        mem(1'b0, 32'h0);
        checks++; if (ivalid !== 1'b1 || ipc !== 32'h0040_0000 || instr !== word_at(32'h0040_0000)) begin errors++; $display("FAIL rq_first got %b/%h/%h want 1/00400000/%h", ivalid, ipc, instr, word_at(32'h0040_0000)); end
    endtask

    initial begin
        rst    = 1'b1;
        redir  = 1'b0;
        freeze = 1'b0;
        alt    = 32'h0;
        mem(1'b0, 32'h0);
        #2;
        test_reset();
        test_zero_wait();
        test_redirect_same_cycle();
        test_slow_ack();
        test_redirect_latency();
        test_freeze();
        test_wrap();
        test_reset_in_squash();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
